// File: rtl/enigma_rotor_stepper_pkg.sv
// Shared types and constants for the Enigma rotor stepper and its scrambler.
package enigma_rotor_stepper_pkg;

    localparam int unsigned ALPHA    = 26;
    localparam int unsigned LETTER_W = 5;

    typedef logic [LETTER_W-1:0] letter_t;

    localparam letter_t ALPHA_L     = LETTER_W'(ALPHA);
    localparam letter_t LAST_LETTER = LETTER_W'(ALPHA - 1);

    localparam logic [1:0] SEL_R = 2'd0;
    localparam logic [1:0] SEL_M = 2'd1;
    localparam logic [1:0] SEL_L = 2'd2;

    typedef enum logic [1:0] {IDLE, STEP, EVAL, OUT} state_e;

    typedef struct packed {
        letter_t l;
        letter_t m;
        letter_t r;
    } rotor_pos_t;

    // Advance one letter position, wrapping the last letter back to A.
    function automatic letter_t inc_wrap(input letter_t x);
        return (x == LAST_LETTER) ? '0 : x + letter_t'(1);
    endfunction

endpackage

// File: rtl/enigma_rotor_stepper_if.sv
// Keypress and encoded-letter valid/ready channels of the rotor stepper.
interface enigma_rotor_stepper_if;
    import enigma_rotor_stepper_pkg::*;

    logic    key_valid;
    logic    key_ready;
    letter_t key_code;
    logic    out_valid;
    logic    out_ready;
    letter_t out_char;

    modport master (
        output key_valid, key_code, out_ready,
        input  key_ready, out_valid, out_char
    );

    modport slave (
        input  key_valid, key_code, out_ready,
        output key_ready, out_valid, out_char
    );

endinterface

// File: rtl/enigma_rotor_stepper_step_next.sv
// Combinational next rotor positions, including the middle-rotor double step.
module rotor_step_next
    import enigma_rotor_stepper_pkg::*;
#(
    parameter int unsigned NOTCH_R = 21,
    parameter int unsigned NOTCH_M = 4
) (
    input  rotor_pos_t cur_pos,
    output rotor_pos_t next_pos_c
);

    logic r_at_notch;
    logic m_at_notch;

    // Middle steps on its own notch too, which produces the double step.
    always_comb begin
        r_at_notch   = (cur_pos.r == LETTER_W'(NOTCH_R));
        m_at_notch   = (cur_pos.m == LETTER_W'(NOTCH_M));
        next_pos_c.r = inc_wrap(cur_pos.r);
        next_pos_c.m = (r_at_notch || m_at_notch) ? inc_wrap(cur_pos.m) : cur_pos.m;
        next_pos_c.l = m_at_notch ? inc_wrap(cur_pos.l) : cur_pos.l;
    end

endmodule

// File: rtl/enigma_rotor_stepper.sv
// Keypress sequencer: steps rotors, presents letter to the scrambler, holds the result.
module enigma_rotor_stepper
    import enigma_rotor_stepper_pkg::*;
#(
    parameter int unsigned NOTCH_R = 21,
    parameter int unsigned NOTCH_M = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    enigma_rotor_stepper_if.slave        bus,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_sel,
    input  letter_t                      cfg_pos,
    output letter_t                      pos_l,
    output letter_t                      pos_m,
    output letter_t                      pos_r,
    output letter_t                      scr_in,
    input  letter_t                      scr_out,
    output logic                         key_err
);

    state_e     state_q, state_d;
    rotor_pos_t pos_q, pos_d, pos_step;
    letter_t    scr_in_q, scr_in_d;
    letter_t    out_char_q, out_char_d;
    logic       out_valid_q, out_valid_d;
    logic       key_err_q, key_err_d;
    logic       key_accept;

    rotor_step_next #(
        .NOTCH_R (NOTCH_R),
        .NOTCH_M (NOTCH_M)
    ) u_step_next (
        .cur_pos    (pos_q),
        .next_pos_c (pos_step)
    );

    // A config write in the same cycle blocks keypresses.
    assign bus.key_ready = (state_q == IDLE) && !cfg_we;
    assign key_accept    = bus.key_valid && bus.key_ready;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        scr_in_d    = scr_in_q;
        out_char_d  = out_char_q;
        out_valid_d = out_valid_q;
        key_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we && (cfg_pos < ALPHA_L)) begin
                    if (cfg_sel == SEL_R)      pos_d.r = cfg_pos;
                    else if (cfg_sel == SEL_M) pos_d.m = cfg_pos;
                    else if (cfg_sel == SEL_L) pos_d.l = cfg_pos;
                end
                if (key_accept) begin
                    if (bus.key_code < ALPHA_L) begin
                        scr_in_d = bus.key_code;
                        state_d  = STEP;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            STEP: begin
                pos_d   = pos_step;
                state_d = EVAL;
            end
            EVAL: begin
                out_char_d  = scr_out;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            scr_in_q    <= '0;
            out_char_q  <= '0;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            scr_in_q    <= scr_in_d;
            out_char_q  <= out_char_d;
            out_valid_q <= out_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    assign pos_l         = pos_q.l;
    assign pos_m         = pos_q.m;
    assign pos_r         = pos_q.r;
    assign scr_in        = scr_in_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign key_err       = key_err_q;

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Directed bench for enigma_rotor_stepper with a simple arithmetic scrambler stand-in.
module tb_enigma_rotor_stepper;
    import enigma_rotor_stepper_pkg::*;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    letter_t     cfg_pos;
    letter_t     pos_l, pos_m, pos_r;
    letter_t     scr_in;
    letter_t     scr_out;
    logic        key_err;
    int unsigned scr_sum;

    int compared;
    int mismatched;

    enigma_rotor_stepper_if bus ();

    enigma_rotor_stepper dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_pos (cfg_pos),
        .pos_l   (pos_l),
        .pos_m   (pos_m),
        .pos_r   (pos_r),
        .scr_in  (scr_in),
        .scr_out (scr_out),
        .key_err (key_err)
    );

    // Stand-in scrambler: (letter + r + 2m + 3l) mod 26.
    always_comb begin
        scr_sum = 32'(scr_in) + 32'(pos_r) + 2 * 32'(pos_m) + 3 * 32'(pos_l);
        scr_out = LETTER_W'(scr_sum % 26);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input letter_t p);
        cfg_we  = 1'b1;
        cfg_sel = sel;
        cfg_pos = p;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic press_key(input letter_t c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({pos_l, pos_m, pos_r} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_pos: got %h want 0", {pos_l, pos_m, pos_r});
        end
        compared++;
        if ({scr_in, bus.out_char, bus.out_valid, key_err, bus.key_ready} !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_out: scr_in=%0d out_char=%0d out_valid=%b key_err=%b key_ready=%b",
                     scr_in, bus.out_char, bus.out_valid, key_err, bus.key_ready);
        end
    endtask

    task automatic test_single_key();
        bus.out_ready = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 5'd0;
        compared++;
        if (bus.key_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL single_ready: got %b want 1", bus.key_ready);
        end
        tick();
        bus.key_valid = 1'b0;
        compared++;
        if ({bus.out_valid, pos_l, pos_m, pos_r} !== {1'b0, 5'd0, 5'd0, 5'd0}) begin
            mismatched++;
            $display("FAIL single_accept: valid=%b pos=%0d,%0d,%0d want 0 0,0,0", bus.out_valid, pos_l, pos_m, pos_r);
        end
        tick();
        compared++;
        if ({bus.out_valid, pos_l, pos_m, pos_r} !== {1'b0, 5'd0, 5'd0, 5'd1}) begin
            mismatched++;
            $display("FAIL single_step: valid=%b pos=%0d,%0d,%0d want 0 0,0,1", bus.out_valid, pos_l, pos_m, pos_r);
        end
        tick();
        compared++;
        if ({bus.out_valid, bus.out_char, bus.key_ready} !== {1'b1, 5'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL single_out: valid=%b char=%0d key_ready=%b want 1 1 0", bus.out_valid, bus.out_char, bus.key_ready);
        end
        tick();
        compared++;
        if ({bus.out_valid, bus.key_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL single_done: valid=%b key_ready=%b want 0 1", bus.out_valid, bus.key_ready);
        end
    endtask

    task automatic test_double_step();
        letter_t keys  [3] = '{5'd7, 5'd4, 5'd11};
        letter_t exp_l [3] = '{5'd0, 5'd0, 5'd1};
        letter_t exp_m [3] = '{5'd3, 5'd4, 5'd5};
        letter_t exp_r [3] = '{5'd21, 5'd22, 5'd23};
        letter_t exp_c [3] = '{5'd8, 5'd8, 5'd21};
        bus.out_ready = 1'b1;
        cfg_write(SEL_L, 5'd0);
        cfg_write(SEL_M, 5'd3);
        cfg_write(SEL_R, 5'd20);
        compared++;
        if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd3, 5'd20}) begin
            mismatched++;
            $display("FAIL cfg_adu: got %0d,%0d,%0d want 0,3,20", pos_l, pos_m, pos_r);
        end
        for (int i = 0; i < 3; i++) begin
            press_key(keys[i]);
            tick();
            compared++;
            if ({pos_l, pos_m, pos_r} !== {exp_l[i], exp_m[i], exp_r[i]}) begin
                mismatched++;
                $display("FAIL dstep_pos[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d",
                         i, pos_l, pos_m, pos_r, exp_l[i], exp_m[i], exp_r[i]);
            end
            tick();
            compared++;
            if ({bus.out_valid, bus.out_char} !== {1'b1, exp_c[i]}) begin
                mismatched++;
                $display("FAIL dstep_char[%0d]: valid=%b char=%0d want 1 %0d", i, bus.out_valid, bus.out_char, exp_c[i]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1;
        cfg_write(SEL_L, 5'd25);
        cfg_write(SEL_M, 5'd25);
        cfg_write(SEL_R, 5'd25);
        cfg_write(2'd3, 5'd5);
        cfg_write(SEL_R, 5'd30);
        compared++;
        if ({pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd25}) begin
            mismatched++;
            $display("FAIL cfg_ignore: got %0d,%0d,%0d want 25,25,25", pos_l, pos_m, pos_r);
        end
        press_key(5'd0);
        tick();
        compared++;
        if ({pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd0}) begin
            mismatched++;
            $display("FAIL wrap_pos: got %0d,%0d,%0d want 25,25,0", pos_l, pos_m, pos_r);
        end
        tick();
        compared++;
        if ({bus.out_valid, bus.out_char} !== {1'b1, 5'd21}) begin
            mismatched++;
            $display("FAIL wrap_char: valid=%b char=%0d want 1 21", bus.out_valid, bus.out_char);
        end
        tick();
    endtask

    task automatic test_bad_key();
        compared++;
        if (key_err !== 1'b0) begin
            mismatched++;
            $display("FAIL badkey_pre: key_err=%b want 0", key_err);
        end
        press_key(5'd27);
        compared++;
        if ({key_err, bus.key_ready, bus.out_valid} !== 3'b110) begin
            mismatched++;
            $display("FAIL badkey_pulse: key_err=%b key_ready=%b valid=%b want 1 1 0", key_err, bus.key_ready, bus.out_valid);
        end
        tick();
        compared++;
        if ({key_err, bus.key_ready, bus.out_valid} !== 3'b010) begin
            mismatched++;
            $display("FAIL badkey_end: key_err=%b key_ready=%b valid=%b want 0 1 0", key_err, bus.key_ready, bus.out_valid);
        end
        compared++;
        if ({pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd0}) begin
            mismatched++;
            $display("FAIL badkey_pos: got %0d,%0d,%0d want 25,25,0", pos_l, pos_m, pos_r);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        press_key(5'd2);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            cfg_we  = 1'b1;
            cfg_sel = SEL_R;
            cfg_pos = 5'd3;
            tick();
            compared++;
            if ({bus.out_valid, bus.out_char, bus.key_ready, pos_l, pos_m, pos_r} !==
                {1'b1, 5'd24, 1'b0, 5'd25, 5'd25, 5'd1}) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: valid=%b char=%0d key_ready=%b pos=%0d,%0d,%0d want 1 24 0 25,25,1",
                         i, bus.out_valid, bus.out_char, bus.key_ready, pos_l, pos_m, pos_r);
            end
        end
        cfg_we        = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        compared++;
        if ({bus.out_valid, bus.key_ready, pos_r} !== {1'b0, 1'b1, 5'd1}) begin
            mismatched++;
            $display("FAIL bp_release: valid=%b key_ready=%b pos_r=%0d want 0 1 1", bus.out_valid, bus.key_ready, pos_r);
        end
    endtask

    task automatic test_reset_in_step();
        bus.out_ready = 1'b1;
        cfg_write(SEL_L, 5'd0);
        cfg_write(SEL_M, 5'd3);
        cfg_write(SEL_R, 5'd21);
        press_key(5'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if ({pos_l, pos_m, pos_r, scr_in, bus.out_char, bus.out_valid, key_err} !== 27'd0) begin
            mismatched++;
            $display("FAIL rst_step: pos=%0d,%0d,%0d scr_in=%0d char=%0d valid=%b err=%b want all 0",
                     pos_l, pos_m, pos_r, scr_in, bus.out_char, bus.out_valid, key_err);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if ({bus.out_valid, bus.key_ready} !== 2'b01) begin
                mismatched++;
                $display("FAIL rst_after[%0d]: valid=%b key_ready=%b want 0 1", i, bus.out_valid, bus.key_ready);
            end
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_sel       = 2'd0;
        cfg_pos       = '0;
        bus.key_valid = 1'b0;
        bus.key_code  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_key();
        test_double_step();
        test_wrap();
        test_bad_key();
        test_backpressure();
        test_reset_in_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
